// File: rtl/apb_wbuf_sdram.sv
// apb_wbuf_sdram: APB posted-write buffer in front of the SDRAM APB controller.
// Upstream writes are absorbed into a FIFO and complete in their access cycle;
// the FIFO drains downstream in order. Reads issue only once the FIFO is empty.
// Optional build macro APB_WBUF_ERR_LATCH_EN: a downstream error on a drained
// write is held in a sticky flag and reported on the next upstream read.

package apb_wbuf_sdram_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // One buffered write
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbuf_entry_t;
endpackage

module apb_wbuf_sdram
    import apb_wbuf_sdram_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic              in_pwrite,
    input  logic [DATA_W-1:0] in_pwdata,
    input  logic [STRB_W-1:0] in_pstrb,
    output logic              in_pready,
    output logic [DATA_W-1:0] in_prdata,
    output logic              in_pslverr,
    output logic [ADDR_W-1:0] out_paddr,
    output logic              out_psel,
    output logic              out_penable,
    output logic              out_pwrite,
    output logic [DATA_W-1:0] out_pwdata,
    output logic [STRB_W-1:0] out_pstrb,
    input  logic              out_pready,
    input  logic [DATA_W-1:0] out_prdata,
    input  logic              out_pslverr
);

    localparam int unsigned PTR_P1_W = PTR_W + 1;

    typedef enum logic [1:0] {
        M_IDLE,
        M_SETUP,
        M_ACCESS,
        M_RESP
    } mst_state_t;

    mst_state_t          state, state_nxt;
    logic [PTR_P1_W-1:0] wr_ptr, rd_ptr;
    wbuf_entry_t         mem [DEPTH];
    wbuf_entry_t         head;
    logic                full, empty, push, pop, rd_req;
    logic                load_wr, load_rd, rd_done;
    logic                rsp_err, rsp_err_d;

    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}};
    assign empty   = (wr_ptr == rd_ptr);
    assign head    = mem[rd_ptr[PTR_W-1:0]];
    assign rd_req  = in_psel & in_penable & ~in_pwrite;
    assign push    = in_psel & in_penable & in_pwrite & ~full;
    assign pop     = (state == M_ACCESS) & out_pready & out_pwrite;
    assign rd_done = (state == M_ACCESS) & out_pready & ~out_pwrite;

    // Writes complete in their access cycle; reads complete in M_RESP
    assign in_pready  = push | (state == M_RESP);
    assign in_pslverr = (state == M_RESP) & rsp_err;

`ifdef APB_WBUF_ERR_LATCH_EN
    logic err_flag;

    // Sticky write error, consumed by the next read response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_flag <= 1'b0;
        end else if (pop && out_pslverr) begin
            err_flag <= 1'b1;
        end else if (state == M_RESP) begin
            err_flag <= 1'b0;
        end
    end

    assign rsp_err_d = out_pslverr | err_flag;
`else
    assign rsp_err_d = out_pslverr;
`endif

    // FIFO storage; contents are don't-care while pointers say empty
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= '{addr: in_paddr, data: in_pwdata, strb: in_pstrb};
        end
    end

    // FIFO pointers with wrap bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_P1_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_P1_W'(1);
        end
    end

    // Master FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= M_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Master FSM next state; buffered writes win over a pending read
    always_comb begin
        state_nxt = state;
        load_wr   = 1'b0;
        load_rd   = 1'b0;
        case (state)
            M_IDLE: begin
                if (!empty) begin
                    state_nxt = M_SETUP;
                    load_wr   = 1'b1;
                end else if (rd_req) begin
                    state_nxt = M_SETUP;
                    load_rd   = 1'b1;
                end
            end
            M_SETUP:  state_nxt = M_ACCESS;
            M_ACCESS: begin
                if (out_pready) begin
                    state_nxt = out_pwrite ? M_IDLE : M_RESP;
                end
            end
            M_RESP:   state_nxt = M_IDLE;
            default:  state_nxt = M_IDLE;
        endcase
    end

    // Registered master bus and read response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_psel    <= 1'b0;
            out_penable <= 1'b0;
            out_pwrite  <= 1'b0;
            out_paddr   <= '0;
            out_pwdata  <= '0;
            out_pstrb   <= '0;
            in_prdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            out_psel    <= (state_nxt == M_SETUP) || (state_nxt == M_ACCESS);
            out_penable <= (state_nxt == M_ACCESS);
            if (load_wr) begin
                out_pwrite <= 1'b1;
                out_paddr  <= head.addr;
                out_pwdata <= head.data;
                out_pstrb  <= head.strb;
            end else if (load_rd) begin
                out_pwrite <= 1'b0;
                out_paddr  <= in_paddr;
                out_pwdata <= '0;
                out_pstrb  <= '0;
            end
            if (rd_done) begin
                in_prdata <= out_prdata;
                rsp_err   <= rsp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_apb_wbuf_sdram.sv
// Directed bench for apb_wbuf_sdram (default DEPTH=4).
module tb_apb_wbuf_sdram;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    int n_checks = 0;
    int n_errors = 0;

`ifdef APB_WBUF_ERR_LATCH_EN
    localparam logic EXP_STICKY = 1'b1;
`else
    localparam logic EXP_STICKY = 1'b0;
`endif

    apb_wbuf_sdram dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_paddr   (in_paddr),
        .in_psel    (in_psel),
        .in_penable (in_penable),
        .in_pwrite  (in_pwrite),
        .in_pwdata  (in_pwdata),
        .in_pstrb   (in_pstrb),
        .in_pready  (in_pready),
        .in_prdata  (in_prdata),
        .in_pslverr (in_pslverr),
        .out_paddr  (out_paddr),
        .out_psel   (out_psel),
        .out_penable(out_penable),
        .out_pwrite (out_pwrite),
        .out_pwdata (out_pwdata),
        .out_pstrb  (out_pstrb),
        .out_pready (out_pready),
        .out_prdata (out_prdata),
        .out_pslverr(out_pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Setup + access; returns with access held at the negedge of the ready cycle
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int waits);
        @(posedge clock); #1;
        in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b1;
        in_paddr = addr; in_pwdata = data; in_pstrb = strb;
        @(posedge clock); #1;
        in_penable = 1'b1;
        waits = 0;
        @(negedge clock);
        while (!in_pready && waits < 50) begin
            @(posedge clock); #1;
            waits++;
            @(negedge clock);
        end
    endtask

    task automatic bus_idle();
        @(posedge clock); #1;
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    // Full read; lat counts cycles from setup to the in_pready cycle
    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic err, output int lat);
        @(posedge clock); #1;
        in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0;
        in_paddr = addr; in_pwdata = '0; in_pstrb = '0;
        @(posedge clock); #1;
        in_penable = 1'b1;
        lat = 1;
        @(negedge clock);
        while (!in_pready && lat < 50) begin
            @(posedge clock); #1;
            lat++;
            @(negedge clock);
        end
        data = in_prdata;
        err  = in_pslverr;
        @(posedge clock); #1;
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waits;
        int          lat;
        int          k;
        logic        got, wr_done, rd_early, stale, acc_seen, e;
        logic [31:0] model, d;
        logic [3:0]  acc_strb;

        reset_n = 1'b0;
        in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
        in_pwdata = '0; in_pstrb = '0;
        out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_out_psel",    32'(out_psel), 32'd0);
        check("rst_out_penable", 32'(out_penable), 32'd0);
        check("rst_out_paddr",   out_paddr, 32'd0);
        check("rst_out_pstrb",   32'(out_pstrb), 32'd0);
        check("rst_in_pready",   32'(in_pready), 32'd0);
        check("rst_in_prdata",   in_prdata, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Single posted write and its downstream setup/access phases
        apb_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, waits);
        check("t1_wait", 32'(waits), 32'd0);
        check("t1_pslverr", 32'(in_pslverr), 32'd0);
        bus_idle();
        @(negedge clock);
        check("t1_idle_psel", 32'(out_psel), 32'd0);
        @(posedge clock); #1;
        out_pready = 1'b1;
        @(negedge clock);
        check("t1_setup_psel",    32'(out_psel), 32'd1);
        check("t1_setup_penable", 32'(out_penable), 32'd0);
        check("t1_setup_pwrite",  32'(out_pwrite), 32'd1);
        check("t1_setup_addr",    out_paddr, 32'h8000_0010);
        check("t1_setup_data",    out_pwdata, 32'hDEAD_BEEF);
        check("t1_setup_strb",    32'(out_pstrb), 32'hF);
        @(posedge clock); #1;
        @(negedge clock);
        check("t1_acc_psel",    32'(out_psel), 32'd1);
        check("t1_acc_penable", 32'(out_penable), 32'd1);
        check("t1_acc_addr",    out_paddr, 32'h8000_0010);
        check("t1_acc_data",    out_pwdata, 32'hDEAD_BEEF);
        check("t1_acc_strb",    32'(out_pstrb), 32'hF);
        @(posedge clock); #1;
        out_pready = 1'b0;
        @(negedge clock);
        check("t1_done_psel", 32'(out_psel), 32'd0);

        // Five back-to-back writes into a 4-deep FIFO with a stalled drain
        for (int i = 1; i <= 4; i++) begin
            apb_write(32'h0000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, waits);
            check($sformatf("t2_w%0d_wait", i), 32'(waits), 32'd0);
        end
        @(posedge clock); #1;
        in_penable = 1'b0;
        in_paddr = 32'h0000_0114; in_pwdata = 32'hA000_0005;
        @(posedge clock); #1;
        in_penable = 1'b1;
        @(negedge clock);
        check("t2_w5_stall0", 32'(in_pready), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("t2_w5_stall1", 32'(in_pready), 32'd0);
        check("t2_head_acc",  32'({out_psel, out_penable}), 32'd3);
        check("t2_head_addr", out_paddr, 32'h0000_0104);
        @(posedge clock); #1;
        out_pready = 1'b1;
        @(negedge clock);
        check("t2_w5_nobypass", 32'(in_pready), 32'd0);
        @(posedge clock); #1;
        out_pready = 1'b0;
        @(negedge clock);
        check("t2_w5_done", 32'(in_pready), 32'd1);
        bus_idle();
        out_pready = 1'b1;
        k = 2;
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(negedge clock);
            if (out_psel && out_penable && out_pready) begin
                check($sformatf("t2_drain%0d_addr", k), out_paddr, 32'h0000_0100 + 32'(k * 4));
                check($sformatf("t2_drain%0d_data", k), out_pwdata, 32'hA000_0000 + 32'(k));
                k++;
            end
            @(posedge clock); #1;
        end
        check("t2_drain_count", 32'(k), 32'd6);

        // Write then read of the same address: the read waits for the write
        out_pready = 1'b0;
        apb_write(32'h8000_0000, 32'h1234_5678, 4'hF, waits);
        check("t3_wait", 32'(waits), 32'd0);
        @(posedge clock); #1;
        in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0;
        in_paddr = 32'h8000_0000;
        @(posedge clock); #1;
        in_penable = 1'b1;
        model = '0; wr_done = 1'b0; rd_early = 1'b0; got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            out_pready = (i >= 2);
            out_prdata = model;
            @(negedge clock);
            if (out_psel && !out_pwrite && !wr_done) rd_early = 1'b1;
            if (out_psel && out_penable && out_pready && out_pwrite) begin
                wr_done = 1'b1;
                model = out_pwdata;
            end
            if (in_pready) begin
                got = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check("t3_rd_done",  32'(got), 32'd1);
        check("t3_order",    32'(rd_early), 32'd0);
        check("t3_prdata",   in_prdata, 32'h1234_5678);
        check("t3_pslverr",  32'(in_pslverr), 32'd0);
        bus_idle();

        // Minimum-latency read with an empty FIFO
        out_pready = 1'b1; out_prdata = 32'hCAFE_F00D; out_pslverr = 1'b0;
        @(posedge clock); #1;
        in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0;
        in_paddr = 32'h8000_0040;
        lat = 0; acc_seen = 1'b0; acc_strb = 4'hF;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock); #1;
            in_penable = 1'b1;
            @(negedge clock);
            if (out_psel && out_penable) begin
                acc_seen = 1'b1;
                acc_strb = out_pstrb;
            end
            if (in_pready) begin
                lat = c;
                break;
            end
        end
        check("t4_latency", 32'(lat), 32'd4);
        check("t4_prdata",  in_prdata, 32'hCAFE_F00D);
        check("t4_acc",     32'(acc_seen), 32'd1);
        check("t4_pstrb",   32'(acc_strb), 32'd0);
        bus_idle();

        // Reset with three entries buffered
        out_pready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apb_write(32'h0000_0200 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'h5, waits);
            check($sformatf("t5_w%0d_wait", i), 32'(waits), 32'd0);
        end
        bus_idle();
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock);
        check("t5_pre_acc", 32'({out_psel, out_penable}), 32'd3);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_psel",    32'(out_psel), 32'd0);
        check("t5_rst_penable", 32'(out_penable), 32'd0);
        check("t5_rst_pwrite",  32'(out_pwrite), 32'd0);
        check("t5_rst_paddr",   out_paddr, 32'd0);
        check("t5_rst_pwdata",  out_pwdata, 32'd0);
        check("t5_rst_pstrb",   32'(out_pstrb), 32'd0);
        check("t5_rst_prdata",  in_prdata, 32'd0);
        check("t5_rst_pready",  32'(in_pready), 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        out_pready = 1'b1;
        stale = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (out_psel) stale = 1'b1;
            @(posedge clock); #1;
        end
        check("t5_no_stale", 32'(stale), 32'd0);

        // Downstream write error, then two reads; a read's own error last
        out_pslverr = 1'b1;
        apb_write(32'h8000_0080, 32'h5555_AAAA, 4'h3, waits);
        check("t6_wait", 32'(waits), 32'd0);
        bus_idle();
        repeat (6) begin @(posedge clock); #1; end
        out_pslverr = 1'b0;
        out_prdata = 32'h0BAD_0001;
        apb_read(32'h8000_0080, d, e, lat);
        check("t6_rd1_lat",  32'(lat), 32'd4);
        check("t6_rd1_data", d, 32'h0BAD_0001);
        check("t6_rd1_err",  32'(e), 32'(EXP_STICKY));
        out_prdata = 32'h0BAD_0002;
        apb_read(32'h8000_0084, d, e, lat);
        check("t6_rd2_lat",  32'(lat), 32'd4);
        check("t6_rd2_data", d, 32'h0BAD_0002);
        check("t6_rd2_err",  32'(e), 32'd0);
        out_pslverr = 1'b1;
        apb_read(32'h8000_0088, d, e, lat);
        check("t6_rd3_err",  32'(e), 32'd1);
        out_pslverr = 1'b0;

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
